// File: rtl/psum_pingpong_acc.sv
// psum_pingpong_acc: rotating multi-bank output psum buffer with accumulate.
// The fill side writes or read-modify-writes words into one bank across kij passes.
// The drain side streams completed tiles from another bank through a two-stage read pipeline.
// Optional macro RELU_OUT_EN: clamp negative lanes to zero on the drain output register.
module psum_pingpong_acc #(
   parameter int unsigned psum_bw = 16,
   parameter int unsigned col     = 8,
   parameter int unsigned depth   = 64,
   parameter int unsigned addr_bw = 6,
   parameter int unsigned banks   = 2,
   parameter int unsigned bank_bw = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [psum_bw*col-1:0] in_data,
   input  logic                   in_acc,
   input  logic                   in_last,
   input  logic                   in_done,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [psum_bw*col-1:0] out_data,
   output logic                   out_last,
   output logic [bank_bw-1:0]     fill_bank,
   output logic [bank_bw-1:0]     drain_bank,
   output logic                   ovf
);

   localparam int unsigned word_bw = psum_bw * col;
   localparam int unsigned len_bw  = addr_bw + 1;

   typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_DRAIN} bank_st_t;

   // Lane-wise wrapping add; carries never cross lane boundaries.
   function automatic logic [word_bw-1:0] lane_add(input logic [word_bw-1:0] a,
                                                   input logic [word_bw-1:0] b);
      logic [word_bw-1:0] r;
      for (int unsigned k = 0; k < col; k++)
         r[k*psum_bw +: psum_bw] = a[k*psum_bw +: psum_bw] + b[k*psum_bw +: psum_bw];
      return r;
   endfunction

`ifdef RELU_OUT_EN
   // Zero every lane whose sign bit is set.
   function automatic logic [word_bw-1:0] relu(input logic [word_bw-1:0] w);
      logic [word_bw-1:0] r;
      for (int unsigned k = 0; k < col; k++)
         r[k*psum_bw +: psum_bw] = w[k*psum_bw + psum_bw - 1] ? '0 : w[k*psum_bw +: psum_bw];
      return r;
   endfunction
`endif

   logic [word_bw-1:0] mem [banks][depth];

   bank_st_t           st_q  [banks];
   bank_st_t           st_d  [banks];
   logic [len_bw-1:0]  len_q [banks];
   logic [len_bw-1:0]  len_d [banks];

   logic [bank_bw-1:0] fill_d, drain_d, fill_nxt_c, drain_nxt_c;
   logic [addr_bw-1:0] wp_q, wp_d, rp_q, rp_d, rd_addr_c;
   logic               later_q, later_d;   // a pass of the current tile has already completed
   logic               drop_q, drop_d;     // overflowed pass: discard words until in_last
   logic               rd_busy_q, rd_busy_d;
   logic               s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
   logic [word_bw-1:0] s1_data_q, s1_data_d;
   logic               out_valid_d, out_last_d, ovf_d, in_ready_d;
   logic [word_bw-1:0] out_data_d;

   logic               in_fire_c, wr_en_c, out_load_c, s1_free_c, rd_go_c, rd_last_c;
   logic [word_bw-1:0] wr_word_c;

   // Bank-rotation increments and write datapath.
   always_comb begin
      fill_nxt_c  = (fill_bank == bank_bw'(banks - 1)) ? '0 : fill_bank + bank_bw'(1);
      drain_nxt_c = (drain_bank == bank_bw'(banks - 1)) ? '0 : drain_bank + bank_bw'(1);
      in_fire_c   = in_valid & in_ready;
      wr_word_c   = (in_acc && later_q) ? lane_add(mem[fill_bank][wp_q], in_data) : in_data;
   end

   // Next-state logic for bank states, pointers and the drain pipeline.
   always_comb begin
      st_d        = st_q;
      len_d       = len_q;
      fill_d      = fill_bank;
      drain_d     = drain_bank;
      wp_d        = wp_q;
      rp_d        = rp_q;
      later_d     = later_q;
      drop_d      = drop_q;
      ovf_d       = ovf;
      rd_busy_d   = rd_busy_q;
      s1_valid_d  = s1_valid_q;
      s1_last_d   = s1_last_q;
      s1_data_d   = s1_data_q;
      out_valid_d = out_valid;
      out_last_d  = out_last;
      out_data_d  = out_data;
      wr_en_c     = 1'b0;
      rd_go_c     = 1'b0;
      rd_last_c   = 1'b0;
      rd_addr_c   = rp_q;

      // Fill side: accept, write, advance pointer / pass / bank.
      if (in_fire_c) begin
         if (st_q[fill_bank] == B_EMPTY) st_d[fill_bank] = B_FILL;
         wr_en_c = !drop_q;
         if (in_last) begin
            wp_d    = '0;
            drop_d  = 1'b0;
            later_d = 1'b1;
            if (in_done) begin
               st_d[fill_bank]  = B_FULL;
               len_d[fill_bank] = drop_q ? len_bw'(depth) : len_bw'(wp_q) + len_bw'(1);
               fill_d           = fill_nxt_c;
               later_d          = 1'b0;
            end
         end else if (!drop_q) begin
            if (wp_q == addr_bw'(depth - 1)) begin
               ovf_d  = 1'b1;
               drop_d = 1'b1;
            end else begin
               wp_d = wp_q + addr_bw'(1);
            end
         end
      end

      // Output register advances whenever it is empty or being consumed.
      out_load_c = !out_valid || out_ready;
      s1_free_c  = !s1_valid_q || out_load_c;
      if (out_load_c) begin
         out_valid_d = s1_valid_q;
         out_last_d  = s1_last_q;
         if (s1_valid_q) begin
`ifdef RELU_OUT_EN
            out_data_d = relu(s1_data_q);
`else
            out_data_d = s1_data_q;
`endif
         end
         s1_valid_d = 1'b0;
      end

      // Read issue: start a FULL bank at address 0, then continue until len words.
      if (st_q[drain_bank] == B_FULL) begin
         rd_go_c   = s1_free_c;
         rd_addr_c = '0;
      end else if (st_q[drain_bank] == B_DRAIN && rd_busy_q) begin
         rd_go_c = s1_free_c;
      end
      if (rd_go_c) begin
         rd_last_c        = (len_bw'(rd_addr_c) + len_bw'(1) == len_q[drain_bank]);
         st_d[drain_bank] = B_DRAIN;
         s1_valid_d       = 1'b1;
         s1_last_d        = rd_last_c;
         s1_data_d        = mem[drain_bank][rd_addr_c];
         rp_d             = rd_addr_c + addr_bw'(1);
         rd_busy_d        = !rd_last_c;
      end

      // Final word consumed: release bank and rotate drain pointer.
      if (out_valid && out_ready && out_last) begin
         st_d[drain_bank] = B_EMPTY;
         drain_d          = drain_nxt_c;
      end

      in_ready_d = (st_d[fill_d] == B_EMPTY) || (st_d[fill_d] == B_FILL);
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q       <= '{default: B_EMPTY};
         len_q      <= '{default: '0};
         fill_bank  <= '0;
         drain_bank <= '0;
         wp_q       <= '0;
         rp_q       <= '0;
         later_q    <= 1'b0;
         drop_q     <= 1'b0;
         ovf        <= 1'b0;
         rd_busy_q  <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_data_q  <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         in_ready   <= 1'b1;
      end else begin
         st_q       <= st_d;
         len_q      <= len_d;
         fill_bank  <= fill_d;
         drain_bank <= drain_d;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         later_q    <= later_d;
         drop_q     <= drop_d;
         ovf        <= ovf_d;
         rd_busy_q  <= rd_busy_d;
         s1_valid_q <= s1_valid_d;
         s1_last_q  <= s1_last_d;
         s1_data_q  <= s1_data_d;
         out_valid  <= out_valid_d;
         out_last   <= out_last_d;
         out_data   <= out_data_d;
         in_ready   <= in_ready_d;
      end
   end

   // Bank storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (reset && wr_en_c) mem[fill_bank][wp_q] <= wr_word_c;
   end

endmodule

// File: tb/tb_psum_pingpong_acc.sv
// Bench for psum_pingpong_acc: directed scenarios plus randomized tiles checked
// against a tile-level accumulation model and an expected-output queue.
`timescale 1ns/1ps
module tb_psum_pingpong_acc;
   localparam int unsigned PB = 16, COL = 2, DEPTH = 4, AW = 2, NB = 2, BW = 1;

   logic          clk = 1'b0, reset = 1'b0;
   logic          in_valid = 1'b0, in_acc = 1'b0, in_last = 1'b0, in_done = 1'b0;
   logic          out_ready = 1'b0;
   logic [31:0]   in_data = '0;
   logic          in_ready, out_valid, out_last, ovf;
   logic [31:0]   out_data;
   logic [BW-1:0] fill_bank, drain_bank;

   psum_pingpong_acc #(.psum_bw(PB), .col(COL), .depth(DEPTH), .addr_bw(AW),
                       .banks(NB), .bank_bw(BW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_acc(in_acc), .in_last(in_last), .in_done(in_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .fill_bank(fill_bank), .drain_bank(drain_bank), .ovf(ovf));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic        skip;   // accept any words up to and including out_last
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0, n_pass = 0;
   bit          rand_mode = 1'b0;
   logic [15:0] pd [4][4][2];
   logic        pacc [4];

   task automatic chk_b(input string tag, input logic obs, input logic expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
   endtask

   task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
   endtask

   function automatic logic [15:0] relu_m(input logic [15:0] v);
`ifdef RELU_OUT_EN
      return ($signed(v) < 0) ? 16'h0000 : v;
`else
      return v;
`endif
   endfunction

   // Output monitor: stability under stall and in-order comparison on handshake.
   logic        hold_prev = 1'b0;
   logic [31:0] data_prev = '0;
   always @(negedge clk) begin
      exp_t e;
      if (hold_prev) begin
         chk_b("stall_valid", out_valid, 1'b1);
         chk_w("stall_data", out_data, data_prev);
      end
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk_w("unexpected_word", 32'(exp_q.size()), 32'd1);
         else begin
            e = exp_q[0];
            if (e.skip) begin
               if (out_last) void'(exp_q.pop_front());
            end else begin
               chk_w("out_data", out_data, e.data);
               chk_b("out_last", out_last, e.last);
               void'(exp_q.pop_front());
            end
         end
      end
      hold_prev = reset && out_valid && !out_ready;
      data_prev = out_data;
   end

   // Random backpressure during the randomized phase.
   initial forever begin
      @(posedge clk); #1;
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   // All tasks below start and end 1ns after a rising edge.
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] l0, input logic [15:0] l1,
                       input logic acc, input logic last, input logic done);
      int n = 0;
      in_valid = 1'b1; in_data = {l1, l0}; in_acc = acc; in_last = last; in_done = done;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      chk_b("in_handshake", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_acc = 1'b0; in_last = 1'b0; in_done = 1'b0;
   endtask

   task automatic setw(input int p, input int i, input int a, input int b);
      pd[p][i][0] = 16'(a);
      pd[p][i][1] = 16'(b);
   endtask

   // Send np passes of len words; model accumulates per tile and queues expected output.
   task automatic do_tile(input int np, input int len);
      logic [15:0] m [4][2];
      exp_t e;
      for (int p = 0; p < np; p++)
         for (int i = 0; i < len; i++) begin
            send(pd[p][i][0], pd[p][i][1], pacc[p], i == len - 1, (i == len - 1) && (p == np - 1));
            for (int k = 0; k < 2; k++)
               m[i][k] = (p > 0 && pacc[p]) ? m[i][k] + pd[p][i][k] : pd[p][i][k];
         end
      for (int i = 0; i < len; i++) begin
         e.data = {relu_m(m[i][1]), relu_m(m[i][0])};
         e.last = (i == len - 1);
         e.skip = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drained(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 2000) begin @(negedge clk); n++; end
      chk_w({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
      chk_b({tag, "_idle"}, out_valid, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      exp_t e;
      int   n;
      int   np, len;

      // Reset values
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk_b("rst_in_ready", in_ready, 1'b1);
      chk_b("rst_out_valid", out_valid, 1'b0);
      chk_b("rst_out_last", out_last, 1'b0);
      chk_w("rst_out_data", out_data, 32'h0);
      chk_b("rst_ovf", ovf, 1'b0);
      chk_w("rst_fill_bank", 32'(fill_bank), 32'd0);
      chk_w("rst_drain_bank", 32'(drain_bank), 32'd0);
      @(posedge clk); #1;

      // Single pass, latency of first output
      out_ready = 1'b1;
      setw(0, 0, 1, 2); setw(0, 1, 3, 4); setw(0, 2, 5, 6); pacc[0] = 1'b0;
      do_tile(1, 3);
      @(negedge clk); chk_b("lat_c0", out_valid, 1'b0);
      @(negedge clk); chk_b("lat_c1", out_valid, 1'b0);
      @(negedge clk); chk_b("lat_c2", out_valid, 1'b1);
      chk_w("lat_first_word", out_data, 32'h0002_0001);
      @(posedge clk); #1;
      wait_drained("single");
      chk_w("fill_adv", 32'(fill_bank), 32'd1);
      chk_w("drain_adv", 32'(drain_bank), 32'd1);

      // Accumulate: in_acc ignored on first pass, then add / overwrite on pass 2
      setw(0, 0, 10, -3); setw(0, 1, 0, 7); setw(1, 0, 5, 5); setw(1, 1, -1, 1);
      pacc[0] = 1'b1; pacc[1] = 1'b1;
      do_tile(2, 2);
      wait_drained("acc_add");
      pacc[1] = 1'b0;
      do_tile(2, 2);
      wait_drained("acc_ovr");

      // Lane wrap without carry into the neighbouring lane
      setw(0, 0, 'h7FFF, 'h1234); setw(1, 0, 1, 2); pacc[0] = 1'b0; pacc[1] = 1'b1;
      do_tile(2, 1);
      wait_drained("wrap");

      // Backpressure / ping-pong
      chk_w("pp_fill_start", 32'(fill_bank), 32'd0);
      chk_w("pp_drain_start", 32'(drain_bank), 32'd0);
      out_ready = 1'b0;
      setw(0, 0, 11, 12); setw(0, 1, 13, 14); pacc[0] = 1'b0;
      do_tile(1, 2);
      setw(0, 0, 21, 22); setw(0, 1, 23, 24); setw(0, 2, 25, 26);
      do_tile(1, 3);
      @(negedge clk);
      chk_b("pp_in_ready_full", in_ready, 1'b0);
      chk_w("pp_fill_wrap", 32'(fill_bank), 32'd0);
      chk_w("pp_drain_hold", 32'(drain_bank), 32'd0);
      chk_b("pp_stall_valid", out_valid, 1'b1);
      @(posedge clk); #1;
      cycles(5);
      out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(out_valid && out_last) && n < 50) begin @(negedge clk); n++; end
      chk_b("pp_a_last_seen", out_last, 1'b1);
      chk_b("pp_in_ready_before_free", in_ready, 1'b0);
      @(negedge clk);
      chk_b("pp_in_ready_after_free", in_ready, 1'b1);
      chk_w("pp_drain_next", 32'(drain_bank), 32'd1);
      @(posedge clk); #1;
      wait_drained("pingpong");

      // Overflow: 5 words without in_last into a 4-deep bank
      for (int i = 0; i < 5; i++) begin
         send(16'(100 + i), 16'(200 + i), 1'b0, 1'b0, 1'b0);
         if (i == 2) chk_b("ovf_before", ovf, 1'b0);
         if (i == 3) chk_b("ovf_set", ovf, 1'b1);
      end
      send(16'd999, 16'd999, 1'b0, 1'b1, 1'b1);
      e.data = '0; e.last = 1'b1; e.skip = 1'b1;
      exp_q.push_back(e);
      wait_drained("ovf_tile");
      chk_b("ovf_sticky", ovf, 1'b1);
      setw(0, 0, 7, -7); setw(0, 1, 8, -8); pacc[0] = 1'b0;
      do_tile(1, 2);
      wait_drained("post_ovf");
      chk_b("ovf_still", ovf, 1'b1);

      // Randomized tiles with random backpressure
      rand_mode = 1'b1;
      for (int t = 0; t < 25; t++) begin
         np  = $urandom_range(1, 3);
         len = $urandom_range(1, 4);
         for (int p = 0; p < np; p++) begin
            pacc[p] = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) setw(p, i, int'($urandom), int'($urandom));
         end
         do_tile(np, len);
      end
      wait_drained("random");
      rand_mode = 1'b0;
      out_ready = 1'b0;

      // Reset during drain
      setw(0, 0, 31, 32); setw(0, 1, 33, 34); setw(0, 2, 35, 36); pacc[0] = 1'b0;
      do_tile(1, 3);
      cycles(4);
      @(negedge clk);
      chk_b("mid_drain_valid", out_valid, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk_b("rst2_out_valid", out_valid, 1'b0);
      chk_b("rst2_in_ready", in_ready, 1'b1);
      chk_w("rst2_fill_bank", 32'(fill_bank), 32'd0);
      chk_w("rst2_drain_bank", 32'(drain_bank), 32'd0);
      chk_b("rst2_ovf", ovf, 1'b0);
      chk_b("rst2_out_last", out_last, 1'b0);
      @(posedge clk); #1;

      // Negative lane on the output path
      out_ready = 1'b1;
      setw(0, 0, -3, 4); pacc[0] = 1'b0;
      do_tile(1, 1);
      wait_drained("neg_lane");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
